// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a Schmidl-Cox training symbol (cyclic prefix + two identical halves)
// to every payload frame on a 32-bit AXI-Stream, with a single output register.
module schmidl_cox_preamble_inserter #(
  parameter int FFT_SIZE = 16,
  parameter int CP_LEN   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(FFT_SIZE/2)-1:0] cfg_wr_addr,
  input  logic [31:0]                   cfg_wr_data,
  output logic                          cfg_wr_err,
  output logic                          busy,
  input  logic [31:0]                   i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [31:0]                   o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready
);

  localparam int HALF = FFT_SIZE / 2;
  localparam int AW   = $clog2(HALF);
  localparam logic [AW-1:0] IDX_LAST = AW'(HALF - 1);
  localparam logic [AW-1:0] CP_START = AW'(HALF - CP_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CP,
    S_HALF_A,
    S_HALF_B,
    S_PAYLOAD
  } state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  idx_reg, idx_next;
  logic [31:0]    tdata_reg, tdata_next;
  logic           tlast_reg, tlast_next;
  logic           tvalid_reg, tvalid_next;
  logic           err_reg, err_next;
  logic           ld;
  logic           cfg_accept;

  logic [31:0]    ram [HALF];
  logic [31:0]    ram_rd;

  // Preamble RAM: no reset, written only while idle so a frame never sees a
  // half-updated training symbol.
  assign cfg_accept = cfg_wr_en && (state_reg == S_IDLE);

  always_ff @(posedge clk) begin
    if (cfg_accept) begin
      ram[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  assign ram_rd = ram[idx_reg];

  assign ld       = !tvalid_reg || o_tready;
  assign i_tready = (state_reg == S_PAYLOAD) && ld;
  assign busy     = (state_reg != S_IDLE);
  assign err_next = cfg_wr_en && (state_reg != S_IDLE);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    tdata_next  = tdata_reg;
    tlast_next  = tlast_reg;
    tvalid_next = tvalid_reg;

    case (state_reg)
      S_IDLE: begin
        if (ld) begin
          tvalid_next = 1'b0;
        end
        // Leaving idle does not need the output register; the first preamble
        // beat simply waits for ld in the next state.
        if (i_tvalid) begin
          if (!enable) begin
            state_next = S_PAYLOAD;
          end else if (CP_LEN == 0) begin
            state_next = S_HALF_A;
            idx_next   = '0;
          end else begin
            state_next = S_CP;
            idx_next   = CP_START;
          end
        end
      end

      S_CP, S_HALF_A, S_HALF_B: begin
        if (ld) begin
          tdata_next  = ram_rd;
          tlast_next  = 1'b0;
          tvalid_next = 1'b1;
          if (idx_reg == IDX_LAST) begin
            idx_next = '0;
            case (state_reg)
              S_CP:     state_next = S_HALF_A;
              S_HALF_A: state_next = S_HALF_B;
              default:  state_next = S_PAYLOAD;
            endcase
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      S_PAYLOAD: begin
        if (ld) begin
          if (i_tvalid) begin
            tdata_next  = i_tdata;
            tlast_next  = i_tlast;
            tvalid_next = 1'b1;
            if (i_tlast) begin
              state_next = S_IDLE;
            end
          end else begin
            tvalid_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else if (clear) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      tdata_reg  <= tdata_next;
      tlast_reg  <= tlast_next;
      tvalid_reg <= tvalid_next;
      err_reg    <= err_next;
    end
  end

  assign o_tdata    = tdata_reg;
  assign o_tlast    = tlast_reg;
  assign o_tvalid   = tvalid_reg;
  assign cfg_wr_err = err_reg;

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Directed self-checking bench for schmidl_cox_preamble_inserter (CP_LEN=4 and CP_LEN=0 builds).
module tb_schmidl_cox_preamble_inserter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clear, enable, cfg_wr_en;
  logic [2:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_wr_err, busy;
  logic [31:0] i_tdata, o_tdata;
  logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;

  logic        cfg_wr_err0, busy0;
  logic [31:0] i0_tdata, o0_tdata;
  logic        i0_tlast, i0_tvalid, i0_tready, o0_tlast, o0_tvalid, o0_tready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;

  // Hand-computed I values of the 20 preamble beats for ram[k] = {k+1, 0}, CP_LEN=4.
  int pre_i [20] = '{5, 6, 7, 8, 1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 3, 4, 5, 6, 7, 8};

  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic [31:0] q0_data[$];
  logic        q0_last[$];

  schmidl_cox_preamble_inserter #(.FFT_SIZE(16), .CP_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_err(cfg_wr_err), .busy(busy),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  schmidl_cox_preamble_inserter #(.FFT_SIZE(16), .CP_LEN(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_err(cfg_wr_err0), .busy(busy0),
    .i_tdata(i0_tdata), .i_tlast(i0_tlast), .i_tvalid(i0_tvalid), .i_tready(i0_tready),
    .o_tdata(o0_tdata), .o_tlast(o0_tlast), .o_tvalid(o0_tvalid), .o_tready(o0_tready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (o_tvalid && o_tready) begin
      q_data.push_back(o_tdata);
      q_last.push_back(o_tlast);
      q_cyc.push_back(cyc);
    end
    if (o0_tvalid && o0_tready) begin
      q0_data.push_back(o0_tdata);
      q0_last.push_back(o0_tlast);
    end
  end

  task automatic write_cfg(input logic [2:0] addr, input logic [31:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = addr;
    cfg_wr_data = data;
    @(posedge clk); #1;
    cfg_wr_en   = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int n, input int first_n, input logic [7:0] last_mask);
    for (int b = 0; b < n; b++) begin
      logic [31:0] d;
      logic        done;
      d = {16'hA000 + 16'(first_n + b), 16'h0000};
      if (sel == 0) begin
        i_tdata = d; i_tlast = last_mask[b]; i_tvalid = 1'b1;
      end else begin
        i0_tdata = d; i0_tlast = last_mask[b]; i0_tvalid = 1'b1;
      end
      if (b == 0) rise_cyc = cyc;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        @(negedge clk);
        if ((sel == 0 && i_tready) || (sel != 0 && i0_tready)) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (sel == 0) i_tvalid = 1'b0; else i0_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int sel, input int n);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (sel == 0 && q_data.size() >= n) break;
      if (sel != 0 && q0_data.size() >= n) break;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    q0_data.delete(); q0_last.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; enable = 1'b1; cfg_wr_en = 1'b0;
    cfg_wr_addr = '0; cfg_wr_data = '0; o_tready = 1'b1; o0_tready = 1'b1;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    i0_tdata = '0; i0_tlast = 1'b0; i0_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid got %b want 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_o_tlast got %b want 0", o_tlast); end
    checks++; if (o_tdata !== 32'h0) begin errors++; $display("FAIL reset_o_tdata got %h want 00000000", o_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_wr_err got %b want 0", cfg_wr_err); end
    checks++; if (i_tready !== 1'b0) begin errors++; $display("FAIL reset_i_tready got %b want 0", i_tready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      write_cfg(3'(k), {16'(k + 1), 16'h0000});
      @(negedge clk);
      checks++;
      if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL idle_write_err addr %0d got %b want 0", k, cfg_wr_err); end
      @(posedge clk); #1;
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic();
    clear_q();
    send_frame(0, 3, 1, 8'b100);
    wait_beats(0, 23);
    checks++;
    if (q_data.size() != 23) begin errors++; $display("FAIL basic_count got %0d want 23", q_data.size()); end
    for (int i = 0; i < 23 && i < q_data.size(); i++) begin
      logic [31:0] e;
      e = (i < 20) ? {16'(pre_i[i]), 16'h0000} : {16'hA000 + 16'(i - 19), 16'h0000};
      checks++;
      if (q_data[i] !== e || q_last[i] !== (i == 22)) begin
        errors++; $display("FAIL basic_beat %0d got %h/%b want %h/%b", i, q_data[i], q_last[i], e, (i == 22));
      end
    end
    if (q_data.size() == 23) begin
      checks++;
      if (q_cyc[0] - rise_cyc != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", q_cyc[0] - rise_cyc); end
      checks++;
      if (q_cyc[22] - q_cyc[0] != 22) begin errors++; $display("FAIL basic_throughput span got %0d want 22", q_cyc[22] - q_cyc[0]); end
    end
    $display("test_basic done: beats=%0d errors=%0d", q_data.size(), errors);
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    pat = 32'hB4D2_6A39;
    clear_q();
    fork
      send_frame(0, 3, 1, 8'b100);
      begin
        logic [31:0] pd;
        logic        pl, pstall;
        pstall = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1;
          o_tready = pat[c % 32];
          @(negedge clk);
          if (pstall) begin
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl) begin
              errors++; $display("FAIL bp_stable cycle %0d got %b/%h/%b want 1/%h/%b", c, o_tvalid, o_tdata, o_tlast, pd, pl);
            end
          end
          pstall = o_tvalid && !o_tready;
          pd = o_tdata; pl = o_tlast;
        end
        @(posedge clk); #1;
        o_tready = 1'b1;
      end
    join
    wait_beats(0, 23);
    checks++;
    if (q_data.size() != 23) begin errors++; $display("FAIL bp_count got %0d want 23", q_data.size()); end
    for (int i = 0; i < 23 && i < q_data.size(); i++) begin
      logic [31:0] e;
      e = (i < 20) ? {16'(pre_i[i]), 16'h0000} : {16'hA000 + 16'(i - 19), 16'h0000};
      checks++;
      if (q_data[i] !== e || q_last[i] !== (i == 22)) begin
        errors++; $display("FAIL bp_beat %0d got %h/%b want %h/%b", i, q_data[i], q_last[i], e, (i == 22));
      end
    end
    $display("test_backpressure done: beats=%0d errors=%0d", q_data.size(), errors);
  endtask

  task automatic test_bypass();
    clear_q();
    enable = 1'b0;
    send_frame(0, 3, 1, 8'b100);
    wait_beats(0, 3);
    enable = 1'b1;
    checks++;
    if (q_data.size() != 3) begin errors++; $display("FAIL bypass_count got %0d want 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      logic [31:0] e;
      e = {16'hA000 + 16'(i + 1), 16'h0000};
      checks++;
      if (q_data[i] !== e || q_last[i] !== (i == 2)) begin
        errors++; $display("FAIL bypass_beat %0d got %h/%b want %h/%b", i, q_data[i], q_last[i], e, (i == 2));
      end
    end
    $display("test_bypass done: beats=%0d errors=%0d", q_data.size(), errors);
  endtask

  task automatic test_cp0();
    clear_q();
    send_frame(1, 3, 1, 8'b100);
    wait_beats(1, 19);
    checks++;
    if (q0_data.size() != 19) begin errors++; $display("FAIL cp0_count got %0d want 19", q0_data.size()); end
    for (int i = 0; i < 19 && i < q0_data.size(); i++) begin
      logic [31:0] e;
      e = (i < 16) ? {16'(pre_i[i + 4]), 16'h0000} : {16'hA000 + 16'(i - 15), 16'h0000};
      checks++;
      if (q0_data[i] !== e || q0_last[i] !== (i == 18)) begin
        errors++; $display("FAIL cp0_beat %0d got %h/%b want %h/%b", i, q0_data[i], q0_last[i], e, (i == 18));
      end
    end
    $display("test_cp0 done: beats=%0d errors=%0d", q0_data.size(), errors);
  endtask

  task automatic test_cfg_busy();
    clear_q();
    i_tdata = {16'hA001, 16'h0000}; i_tlast = 1'b1; i_tvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (q_data.size() >= 5) break;
    end
    write_cfg(3'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (cfg_wr_err !== 1'b1) begin errors++; $display("FAIL busy_err_pulse got %b want 1", cfg_wr_err); end
    @(negedge clk);
    checks++;
    if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL busy_err_width got %b want 0", cfg_wr_err); end
    @(posedge clk); #1;
    send_frame(0, 1, 1, 8'b1);
    wait_beats(0, 21);
    checks++;
    if (q_data.size() != 21) begin errors++; $display("FAIL busy_count got %0d want 21", q_data.size()); end
    for (int i = 0; i < 21 && i < q_data.size(); i++) begin
      logic [31:0] e;
      e = (i < 20) ? {16'(pre_i[i]), 16'h0000} : 32'hA001_0000;
      checks++;
      if (q_data[i] !== e) begin errors++; $display("FAIL busy_ram_beat %0d got %h want %h", i, q_data[i], e); end
    end
    write_cfg(3'd0, 32'h7FFF_0000);
    @(negedge clk);
    checks++;
    if (cfg_wr_err !== 1'b0) begin errors++; $display("FAIL idle_err got %b want 0", cfg_wr_err); end
    @(posedge clk); #1;
    clear_q();
    send_frame(0, 1, 1, 8'b1);
    wait_beats(0, 21);
    checks++;
    if (q_data.size() != 21) begin errors++; $display("FAIL idle_wr_count got %0d want 21", q_data.size()); end
    if (q_data.size() == 21) begin
      checks++;
      if (q_data[4] !== 32'h7FFF_0000) begin errors++; $display("FAIL idle_wr_half_a got %h want 7fff0000", q_data[4]); end
      checks++;
      if (q_data[12] !== 32'h7FFF_0000) begin errors++; $display("FAIL idle_wr_half_b got %h want 7fff0000", q_data[12]); end
      checks++;
      if (q_data[5] !== 32'h0002_0000) begin errors++; $display("FAIL idle_wr_neighbor got %h want 00020000", q_data[5]); end
    end
    write_cfg(3'd0, 32'h0001_0000);
    $display("test_cfg_busy done: errors=%0d", errors);
  endtask

  task automatic test_async_reset();
    clear_q();
    i_tdata = {16'hA001, 16'h0000}; i_tlast = 1'b0; i_tvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (q_data.size() >= 15) break;
    end
    #2;
    reset_n = 1'b0;
    i_tvalid = 1'b0;
    #1;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL async_o_tvalid got %b want 0", o_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++; if (o_tdata !== 32'h0) begin errors++; $display("FAIL async_o_tdata got %h want 00000000", o_tdata); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_frame(0, 3, 1, 8'b100);
    wait_beats(0, 23);
    checks++;
    if (q_data.size() != 23) begin errors++; $display("FAIL async_after_count got %0d want 23", q_data.size()); end
    for (int i = 0; i < 23 && i < q_data.size(); i++) begin
      logic [31:0] e;
      e = (i < 20) ? {16'(pre_i[i]), 16'h0000} : {16'hA000 + 16'(i - 19), 16'h0000};
      checks++;
      if (q_data[i] !== e || q_last[i] !== (i == 22)) begin
        errors++; $display("FAIL async_after_beat %0d got %h/%b want %h/%b", i, q_data[i], q_last[i], e, (i == 22));
      end
    end
    $display("test_async_reset done: beats=%0d errors=%0d", q_data.size(), errors);
  endtask

  task automatic test_clear();
    clear_q();
    i_tdata = {16'hA001, 16'h0000}; i_tlast = 1'b1; i_tvalid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    clear = 1'b1;
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL clear_o_tvalid got %b want 0", o_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", busy); end
    @(posedge clk); #1;
    $display("test_clear done: errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(0, 2, 1, 8'b11);
    wait_beats(0, 42);
    checks++;
    if (q_data.size() != 42) begin errors++; $display("FAIL b2b_count got %0d want 42", q_data.size()); end
    for (int i = 0; i < 42 && i < q_data.size(); i++) begin
      logic [31:0] e;
      int          j;
      j = i % 21;
      e = (j < 20) ? {16'(pre_i[j]), 16'h0000} : {16'hA000 + 16'(i / 21 + 1), 16'h0000};
      checks++;
      if (q_data[i] !== e || q_last[i] !== (j == 20)) begin
        errors++; $display("FAIL b2b_beat %0d got %h/%b want %h/%b", i, q_data[i], q_last[i], e, (j == 20));
      end
    end
    if (q_data.size() == 42) begin
      checks++;
      if (q_cyc[21] - q_cyc[20] != 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", q_cyc[21] - q_cyc[20]); end
    end
    $display("test_back_to_back done: beats=%0d errors=%0d", q_data.size(), errors);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bypass();
    test_cp0();
    test_cfg_busy();
    test_async_reset();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
